// File: rtl/hazard_detect_pkg.sv
// rtl/hazard_detect_pkg.sv - shared pipeline constants for hazard detection
package hazard_detect_pkg;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  localparam int MUL_LAT_DEFAULT = 4;
  localparam int DIV_LAT_DEFAULT = 32;
  localparam int COUNT_W         = 6;

endpackage

// File: rtl/hazard_md_timer.sv
// rtl/hazard_md_timer.sv - occupancy timer for the multi-cycle mult/div unit
module hazard_md_timer
  import hazard_detect_pkg::*;
#(
  parameter int MUL_LAT = MUL_LAT_DEFAULT,
  parameter int DIV_LAT = DIV_LAT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic is_div,
  output logic busy
);

  localparam logic [COUNT_W-1:0] MUL_CNT = COUNT_W'(MUL_LAT - 1);
  localparam logic [COUNT_W-1:0] DIV_CNT = COUNT_W'(DIV_LAT - 1);

  md_state_e          state_q, state_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic [COUNT_W-1:0] start_cnt;

  assign start_cnt = is_div ? DIV_CNT : MUL_CNT;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    case (state_q)
      MD_IDLE: begin
        // A single-cycle operation has nothing left to occupy after issue.
        if (start && (start_cnt != '0)) begin
          state_d = MD_BUSY;
          count_d = start_cnt;
        end
      end
      MD_BUSY: begin
        if (count_q == COUNT_W'(1)) begin
          state_d = MD_IDLE;
          count_d = '0;
        end else begin
          count_d = count_q - COUNT_W'(1);
        end
      end
      default: begin
        state_d = MD_IDLE;
        count_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MD_IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // Reset forces an idle view immediately so a pending mfhi is not held off.
  assign busy = (state_q == MD_BUSY) && !rst;

endmodule

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - load-use and mult/div occupancy stall generation
module hazard_detect
  import hazard_detect_pkg::*;
#(
  parameter int MUL_LAT = MUL_LAT_DEFAULT,
  parameter int DIV_LAT = DIV_LAT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  IdRs,
  input  logic [4:0]  IdRt,
  input  logic        IdUsesRs,
  input  logic        IdUsesRt,
  input  logic        IdIsMulDiv,
  input  logic        IdIsDiv,
  input  logic        IdReadsHiLo,
  input  logic [1:0]  ExMemRead,
  input  logic        ExRegWrite,
  input  logic [4:0]  ExWriteReg,
  input  logic        StatClear,
  output logic        Hazard,
  output logic        PcWrite,
  output logic        IfIdWrite,
  output logic        MdStart,
  output logic        MdBusy,
  output logic [31:0] StallCount
);

  logic        load_use;
  logic        md_conflict;
  logic        md_busy;
  logic [31:0] stall_count_q, stall_count_d;

  // A load into $0 never produces a value worth waiting for.
  assign load_use = (ExMemRead != 2'b00) && ExRegWrite && (ExWriteReg != 5'd0) &&
                    ((IdUsesRs && (IdRs == ExWriteReg)) ||
                     (IdUsesRt && (IdRt == ExWriteReg)));

  assign md_conflict = md_busy && (IdReadsHiLo || IdIsMulDiv);
  assign Hazard      = load_use || md_conflict;
  assign PcWrite     = ~Hazard;
  assign IfIdWrite   = ~Hazard;
  assign MdStart     = IdIsMulDiv && !Hazard && !md_busy;
  assign MdBusy      = md_busy;

  hazard_md_timer #(
    .MUL_LAT (MUL_LAT),
    .DIV_LAT (DIV_LAT)
  ) u_md_timer (
    .clk    (clk),
    .rst    (rst),
    .start  (MdStart),
    .is_div (IdIsDiv),
    .busy   (md_busy)
  );

  always_comb begin
    stall_count_d = stall_count_q;
    if (StatClear) begin
      stall_count_d = '0;
    end else if (Hazard && (stall_count_q != 32'hFFFF_FFFF)) begin
      stall_count_d = stall_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_count_q <= '0;
    end else begin
      stall_count_q <= stall_count_d;
    end
  end

  assign StallCount = stall_count_q;

endmodule

// File: tb/tb_hazard_detect.sv
// tb/tb_hazard_detect.sv - directed self-checking bench for hazard_detect
module tb_hazard_detect;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  IdRs, IdRt;
  logic        IdUsesRs, IdUsesRt;
  logic        IdIsMulDiv, IdIsDiv, IdReadsHiLo;
  logic [1:0]  ExMemRead;
  logic        ExRegWrite;
  logic [4:0]  ExWriteReg;
  logic        StatClear;
  logic        Hazard, PcWrite, IfIdWrite, MdStart, MdBusy;
  logic [31:0] StallCount;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_detect #(
    .MUL_LAT (4),
    .DIV_LAT (32)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .IdRs        (IdRs),
    .IdRt        (IdRt),
    .IdUsesRs    (IdUsesRs),
    .IdUsesRt    (IdUsesRt),
    .IdIsMulDiv  (IdIsMulDiv),
    .IdIsDiv     (IdIsDiv),
    .IdReadsHiLo (IdReadsHiLo),
    .ExMemRead   (ExMemRead),
    .ExRegWrite  (ExRegWrite),
    .ExWriteReg  (ExWriteReg),
    .StatClear   (StatClear),
    .Hazard      (Hazard),
    .PcWrite     (PcWrite),
    .IfIdWrite   (IfIdWrite),
    .MdStart     (MdStart),
    .MdBusy      (MdBusy),
    .StallCount  (StallCount)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    IdRs = 5'd0; IdRt = 5'd0; IdUsesRs = 1'b0; IdUsesRt = 1'b0;
    IdIsMulDiv = 1'b0; IdIsDiv = 1'b0; IdReadsHiLo = 1'b0;
    ExMemRead = 2'd0; ExRegWrite = 1'b0; ExWriteReg = 5'd0;
    StatClear = 1'b0;
  endtask

  task automatic set_ld(input logic [1:0] mr, input logic rw, input logic [4:0] wr,
                        input logic [4:0] rs, input logic [4:0] rt,
                        input logic urs, input logic urt);
    ExMemRead = mr; ExRegWrite = rw; ExWriteReg = wr;
    IdRs = rs; IdRt = rt; IdUsesRs = urs; IdUsesRt = urt;
  endtask

  task automatic ld_vec(input string tag, input logic [1:0] mr, input logic rw,
                        input logic [4:0] wr, input logic [4:0] rs, input logic [4:0] rt,
                        input logic urs, input logic urt, input logic exp);
    set_ld(mr, rw, wr, rs, rt, urs, urt);
    @(negedge clk);
    check(tag, 32'(Hazard), 32'(exp));
    next_cycle();
  endtask

  initial begin
    int hz_cnt;
    int st_cnt;
    clear_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_busy", 32'(MdBusy), 32'd0);
    check("rst_stall", StallCount, 32'd0);
    check("rst_hazard", 32'(Hazard), 32'd0);
    check("rst_pcwrite", 32'(PcWrite), 32'd1);
    next_cycle();

    // lw $5 in EX, add reading $5 in ID
    set_ld(2'd1, 1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0);
    @(negedge clk);
    check("lu_hazard", 32'(Hazard), 32'd1);
    check("lu_pcwrite", 32'(PcWrite), 32'd0);
    check("lu_ifidwrite", 32'(IfIdWrite), 32'd0);
    next_cycle();
    ExMemRead = 2'd0; ExRegWrite = 1'b0;
    @(negedge clk);
    check("lu_bubble_hazard", 32'(Hazard), 32'd0);
    check("lu_bubble_pcwrite", 32'(PcWrite), 32'd1);
    check("lu_stall1", StallCount, 32'd1);
    next_cycle();

    ld_vec("ld_wr0", 2'd1, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0);
    ld_vec("ld_nors", 2'd1, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0);
    ld_vec("ld_rt", 2'd2, 1'b1, 5'd7, 5'd3, 5'd7, 1'b1, 1'b1, 1'b1);
    ld_vec("ld_norw", 2'd1, 1'b0, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0);
    ld_vec("ld_nomem", 2'd0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0);
    ld_vec("ld_nomatch", 2'd3, 1'b1, 5'd9, 5'd8, 5'd10, 1'b1, 1'b1, 1'b0);
    clear_inputs();
    @(negedge clk);
    check("ld_stall2", StallCount, 32'd2);
    StatClear = 1'b1;
    next_cycle();
    StatClear = 1'b0;
    @(negedge clk);
    check("clr_stall", StallCount, 32'd0);
    next_cycle();

    // mult held off by a load-use, then issues once the bubble passes
    set_ld(2'd1, 1'b1, 5'd4, 5'd4, 5'd6, 1'b1, 1'b1);
    IdIsMulDiv = 1'b1; IdIsDiv = 1'b0;
    @(negedge clk);
    check("mul_lu_hazard", 32'(Hazard), 32'd1);
    check("mul_lu_start", 32'(MdStart), 32'd0);
    next_cycle();
    ExMemRead = 2'd0; ExRegWrite = 1'b0;
    @(negedge clk);
    check("mul_c0_start", 32'(MdStart), 32'd1);
    check("mul_c0_busy", 32'(MdBusy), 32'd0);
    check("mul_c0_hazard", 32'(Hazard), 32'd0);
    next_cycle();
    IdIsMulDiv = 1'b0; IdUsesRs = 1'b0; IdUsesRt = 1'b0; IdReadsHiLo = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      check($sformatf("mul_c%0d_busy", i), 32'(MdBusy), 32'd1);
      check($sformatf("mul_c%0d_hazard", i), 32'(Hazard), 32'd1);
      check($sformatf("mul_c%0d_start", i), 32'(MdStart), 32'd0);
      next_cycle();
    end
    @(negedge clk);
    check("mul_c4_busy", 32'(MdBusy), 32'd0);
    check("mul_c4_hazard", 32'(Hazard), 32'd0);
    check("mul_stall", StallCount, 32'd4);
    next_cycle();
    clear_inputs();

    // div followed immediately by another div
    IdIsMulDiv = 1'b1; IdIsDiv = 1'b1;
    @(negedge clk);
    check("div_c0_start", 32'(MdStart), 32'd1);
    next_cycle();
    hz_cnt = 0;
    st_cnt = 0;
    for (int i = 1; i <= 31; i++) begin
      @(negedge clk);
      if (Hazard) hz_cnt++;
      if (MdStart) st_cnt++;
      next_cycle();
    end
    check("div_stall_cycles", 32'(hz_cnt), 32'd31);
    check("div_mid_starts", 32'(st_cnt), 32'd0);
    @(negedge clk);
    check("div_c32_start", 32'(MdStart), 32'd1);
    check("div_c32_hazard", 32'(Hazard), 32'd0);
    next_cycle();
    IdIsMulDiv = 1'b0; IdIsDiv = 1'b0; IdReadsHiLo = 1'b1;
    @(negedge clk);
    check("div2_c1_busy", 32'(MdBusy), 32'd1);
    check("div2_c1_hazard", 32'(Hazard), 32'd1);
    next_cycle();

    // reset in cycle 2 of the second div; mfhi stays in ID
    rst = 1'b1;
    @(negedge clk);
    check("rstmid_busy", 32'(MdBusy), 32'd0);
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    check("rstmid_after_busy", 32'(MdBusy), 32'd0);
    check("rstmid_after_hazard", 32'(Hazard), 32'd0);
    check("rstmid_stall", StallCount, 32'd0);
    next_cycle();
    clear_inputs();

    // saturation and clear priority
    set_ld(2'd1, 1'b1, 5'd12, 5'd12, 5'd0, 1'b1, 1'b0);
    force dut.stall_count_q = 32'hFFFF_FFFE;
    #1 release dut.stall_count_q;
    @(negedge clk);
    check("sat_pre", StallCount, 32'hFFFF_FFFE);
    next_cycle();
    @(negedge clk);
    check("sat_reach", StallCount, 32'hFFFF_FFFF);
    next_cycle();
    @(negedge clk);
    check("sat_hold", StallCount, 32'hFFFF_FFFF);
    check("sat_hazard", 32'(Hazard), 32'd1);
    StatClear = 1'b1;
    next_cycle();
    StatClear = 1'b0;
    @(negedge clk);
    check("sat_clear", StallCount, 32'd0);
    next_cycle();
    @(negedge clk);
    check("sat_clear_inc", StallCount, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
